mul_div_unit: RTL



---
 rtl/mul_div_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Iterative 16-bit unsigned multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, result written back to the register file in a single WB cycle.
module mul_div_unit #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              Start,
   input  logic [1:0]        Op,
   input  logic [DATA_W-1:0] SrcA,
   input  logic [DATA_W-1:0] SrcB,
   input  logic [ADDR_W-1:0] DestReg,
   output logic              Busy,
   output logic              Done,
   output logic [ADDR_W-1:0] WriteReg,
   output logic [DATA_W-1:0] WriteData,
   output logic              RegWre
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] WB   = 2'd2;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [1:0]        op_q, op_d;
   logic [ADDR_W-1:0] dest_q, dest_d;
   logic [DATA_W-1:0] opnd_q, opnd_d;
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;
   logic [ADDR_W-1:0] write_reg_q, write_reg_d;
   logic [DATA_W-1:0] write_data_q, write_data_d;

   logic [DATA_W:0]   mul_sum;
   logic [DATA_W:0]   div_shift;
   logic [DATA_W-1:0] div_diff;
   logic              div_ge;

   // hi/lo is the product pair for multiply (lo starts as the multiplier) and the
   // remainder/quotient pair for divide (lo starts as the dividend). opnd holds the
   // multiplicand or divisor.
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      op_d         = op_q;
      dest_d       = dest_q;
      opnd_d       = opnd_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;

      mul_sum   = {1'b0, hi_q} + ({1'b0, opnd_q} & {(DATA_W + 1){lo_q[0]}});
      div_shift = {hi_q, lo_q[DATA_W-1]};
      div_ge    = div_shift >= {1'b0, opnd_q};
      div_diff  = div_shift[DATA_W-1:0] - opnd_q;

      case (state_q)
         IDLE: begin
            if (Start) begin
               state_d = CALC;
               count_d = '0;
               op_d    = Op;
               dest_d  = DestReg;
               opnd_d  = Op[1] ? SrcB : SrcA;
               hi_d    = '0;
               lo_d    = Op[1] ? SrcA : SrcB;
            end
         end
         CALC: begin
            count_d = count_q + 1'b1;
            if (op_q[1]) begin
               hi_d = div_ge ? div_diff : div_shift[DATA_W-1:0];
               lo_d = {lo_q[DATA_W-2:0], div_ge};
            end else begin
               hi_d = mul_sum[DATA_W:1];
               lo_d = {mul_sum[0], lo_q[DATA_W-1:1]};
            end
            // Op[0] picks the high word: MULH product high half or REMU remainder.
            if (count_q == LAST_CNT) begin
               state_d      = WB;
               write_reg_d  = dest_q;
               write_data_d = op_q[0] ? hi_d : lo_d;
            end
         end
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q      <= IDLE;
         count_q      <= '0;
         op_q         <= '0;
         dest_q       <= '0;
         opnd_q       <= '0;
         hi_q         <= '0;
         lo_q         <= '0;
         write_reg_q  <= '0;
         write_data_q <= '0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         op_q         <= op_d;
         dest_q       <= dest_d;
         opnd_q       <= opnd_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
      end
   end

   // Status decodes straight from state so an async reset drops them at once.
   assign Busy      = (state_q != IDLE);
   assign Done      = (state_q == WB);
   assign RegWre    = (state_q == WB) && (dest_q != '0);
   assign WriteReg  = write_reg_q;
   assign WriteData = write_data_q;

endmodule
